// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared types and constants for the data-memory load/store sequencer.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for a read-latency down-count of up to 3 cycles
    localparam int LAT_CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        RESP
    } lsu_state_t;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// Core-side request/response channel of the load/store sequencer.
interface dmem_lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_lsu_ctrl_align.sv
// Byte/half lane handling: load extract with sign/zero extension and
// read-modify-write merge for sub-word stores.
module lsu_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'd0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'd0, half_v};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3)
            F3_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the core memory stage and BRAM port B.
// Sub-word stores are done as read-modify-write since the BRAM has no byte lanes.
//
//  state | meaning
//  IDLE  | ready for a request
//  ISSUE | BRAM access (read, or the write of a full-word store)
//  WAIT  | counting out the BRAM read latency, data taken on the last cycle
//  WRITE | write back the merged word of a byte/half store
//  RESP  | one-cycle response to the core
module dmem_lsu_ctrl
    import rv_mem_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    dmem_lsu_ctrl_if.slave    core,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout
);

    lsu_state_t           state;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [1:0]           lane_q;
    logic [31:0]          wdata_q;
    logic [LAT_CNT_W-1:0] lat_cnt;

    logic [31:0] offset;
    logic        misalign;
    logic        out_of_win;
    logic        req_err;
    logic        accept;
    logic        is_sw_q;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // The window base is word-aligned, so offset low bits equal addr low bits
    assign offset     = core.req_addr - BASE_ADDR;
    assign out_of_win = |(offset >> (ADDR_W + 2));
    assign misalign   = ((core.req_funct3 == F3_H || core.req_funct3 == F3_HU) && offset[0])
                      || (core.req_funct3 == F3_W && offset[1:0] != 2'b00);
    assign req_err    = f3_illegal(core.req_we, core.req_funct3) || misalign || out_of_win;
    assign accept     = core.req_valid && core.req_ready;
    assign is_sw_q    = we_q && (f3_q == F3_W);

    lsu_align u_align (
        .word       (bram_dout),
        .lane       (lane_q),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            we_q            <= 1'b0;
            f3_q            <= '0;
            lane_q          <= '0;
            wdata_q         <= '0;
            lat_cnt         <= '0;
            core.req_ready  <= 1'b1;
            core.resp_valid <= 1'b0;
            core.resp_rdata <= '0;
            core.resp_err   <= 1'b0;
            bram_en         <= 1'b0;
            bram_we         <= 1'b0;
            bram_addr       <= '0;
            bram_din        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q           <= core.req_we;
                        f3_q           <= core.req_funct3;
                        lane_q         <= offset[1:0];
                        wdata_q        <= core.req_wdata;
                        core.req_ready <= 1'b0;
                        if (req_err) begin
                            state           <= RESP;
                            core.resp_valid <= 1'b1;
                            core.resp_err   <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            bram_en   <= 1'b1;
                            bram_addr <= offset[ADDR_W+1:2];
                            if (core.req_we && core.req_funct3 == F3_W) begin
                                bram_we  <= 1'b1;
                                bram_din <= core.req_wdata;
                            end
                        end
                    end
                end
                ISSUE: begin
                    bram_en  <= 1'b0;
                    bram_we  <= 1'b0;
                    bram_din <= '0;
                    if (is_sw_q) begin
                        state           <= RESP;
                        core.resp_valid <= 1'b1;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_CNT_W'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (we_q) begin
                            state    <= WRITE;
                            bram_en  <= 1'b1;
                            bram_we  <= 1'b1;
                            bram_din <= store_word;
                        end else begin
                            state           <= RESP;
                            core.resp_valid <= 1'b1;
                            core.resp_rdata <= load_data;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    bram_en         <= 1'b0;
                    bram_we         <= 1'b0;
                    bram_din        <= '0;
                    state           <= RESP;
                    core.resp_valid <= 1'b1;
                end
                RESP: begin
                    core.resp_valid <= 1'b0;
                    core.resp_rdata <= '0;
                    core.resp_err   <= 1'b0;
                    core.req_ready  <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench: three sequencers with read latency 1, 2 and 3 run the same
// request stream against their own BRAM models.
module tb_dmem_lsu_ctrl;
    import rv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    always #5 clk = ~clk;

    // live DUT outputs
    logic [31:0] ready_a [3];
    logic [31:0] rv_a    [3];
    logic [31:0] rerr_a  [3];
    logic [31:0] rdat_a  [3];
    logic [31:0] en_a    [3];
    logic [31:0] we_a    [3];
    logic [31:0] addr_a  [3];
    logic [31:0] din_a   [3];
    // per-transaction monitor results
    logic [31:0] act_a      [3];
    logic [31:0] resp_cyc_a [3];
    logic [31:0] en_cnt_a   [3];
    logic [31:0] en_addr_a  [3];
    logic [31:0] we_cnt_a   [3];
    logic [31:0] we_cyc_a   [3];
    logic [31:0] we_din_a   [3];
    logic [31:0] rdata_a    [3];
    logic [31:0] err_a      [3];
    logic [31:0] acc_tot_a  [3];
    logic [31:0] gap_a      [3];
    logic [31:0] resp_tot_a [3];
    logic [31:0] we_tot_a   [3];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int L = g + 1;
        dmem_lsu_ctrl_if u_if ();
        logic        b_en, b_we;
        logic [9:0]  b_addr;
        logic [31:0] b_din, b_dout;
        logic [31:0] mem  [1024];
        logic [31:0] pipe [L];

        assign u_if.req_valid  = req_valid;
        assign u_if.req_we     = req_we;
        assign u_if.req_funct3 = req_funct3;
        assign u_if.req_addr   = req_addr;
        assign u_if.req_wdata  = req_wdata;

        dmem_lsu_ctrl #(.ADDR_W(10), .RD_LAT(L), .BASE_ADDR(32'h0)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .core      (u_if),
            .bram_en   (b_en),
            .bram_we   (b_we),
            .bram_addr (b_addr),
            .bram_din  (b_din),
            .bram_dout (b_dout)
        );

        always @(posedge clk) begin
            if (b_en) begin
                if (b_we) mem[b_addr] <= b_din;
                pipe[0] <= mem[b_addr];
            end
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign b_dout = pipe[L-1];

        logic [31:0] m_tick = '0, m_act = '0, m_cyc = '0, m_resp_cyc = '0;
        logic [31:0] m_en_cnt = '0, m_en_addr = '0, m_we_cnt = '0, m_we_cyc = '0;
        logic [31:0] m_we_din = '0, m_rdata = '0, m_err = '0, m_acc_tot = '0;
        logic [31:0] m_gap = '0, m_last_resp = '0, m_resp_tot = '0, m_we_tot = '0;

        // cycle k after the accept edge is sampled at the k-th following edge
        always @(posedge clk) begin
            m_tick <= m_tick + 1;
            if (rst) begin
                m_act <= '0;
            end else begin
                if (b_we) m_we_tot <= m_we_tot + 1;
                if (m_act != 0) begin
                    m_cyc <= m_cyc + 1;
                    if (b_en) begin
                        m_en_cnt  <= m_en_cnt + 1;
                        m_en_addr <= {22'd0, b_addr};
                    end
                    if (b_we) begin
                        m_we_cnt <= m_we_cnt + 1;
                        m_we_cyc <= m_cyc + 1;
                        m_we_din <= b_din;
                    end
                    if (u_if.resp_valid) begin
                        m_act       <= '0;
                        m_resp_cyc  <= m_cyc + 1;
                        m_rdata     <= u_if.resp_rdata;
                        m_err       <= {31'd0, u_if.resp_err};
                        m_resp_tot  <= m_resp_tot + 1;
                        m_last_resp <= m_tick + 1;
                    end
                end
                if (u_if.req_valid && u_if.req_ready) begin
                    m_act      <= 32'd1;
                    m_cyc      <= '0;
                    m_en_cnt   <= '0;
                    m_we_cnt   <= '0;
                    m_we_cyc   <= '0;
                    m_resp_cyc <= '0;
                    m_acc_tot  <= m_acc_tot + 1;
                    m_gap      <= m_tick + 1 - m_last_resp;
                end
            end
        end

        assign ready_a[g]    = {31'd0, u_if.req_ready};
        assign rv_a[g]       = {31'd0, u_if.resp_valid};
        assign rerr_a[g]     = {31'd0, u_if.resp_err};
        assign rdat_a[g]     = u_if.resp_rdata;
        assign en_a[g]       = {31'd0, b_en};
        assign we_a[g]       = {31'd0, b_we};
        assign addr_a[g]     = {22'd0, b_addr};
        assign din_a[g]      = b_din;
        assign act_a[g]      = m_act;
        assign resp_cyc_a[g] = m_resp_cyc;
        assign en_cnt_a[g]   = m_en_cnt;
        assign en_addr_a[g]  = m_en_addr;
        assign we_cnt_a[g]   = m_we_cnt;
        assign we_cyc_a[g]   = m_we_cyc;
        assign we_din_a[g]   = m_we_din;
        assign rdata_a[g]    = m_rdata;
        assign err_a[g]      = m_err;
        assign acc_tot_a[g]  = m_acc_tot;
        assign gap_a[g]      = m_gap;
        assign resp_tot_a[g] = m_resp_tot;
        assign we_tot_a[g]   = m_we_tot;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((act_a[0] | act_a[1] | act_a[2]) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", act_a[0] | act_a[1] | act_a[2], 32'd0);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = ad; req_wdata = wd; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
    endtask

    // resp cycle = rbase (+ read latency when rlat)
    task automatic chk_txn(input string nm, input int rbase, input bit rlat, input int en_n,
                           input int we_n, input logic [31:0] rd, input logic [31:0] er);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s/cyc/L%0d", nm, i+1), resp_cyc_a[i], 32'(rbase + (rlat ? i + 1 : 0)));
            chk($sformatf("%s/en/L%0d", nm, i+1), en_cnt_a[i], 32'(en_n));
            chk($sformatf("%s/we/L%0d", nm, i+1), we_cnt_a[i], 32'(we_n));
            chk($sformatf("%s/rdata/L%0d", nm, i+1), rdata_a[i], rd);
            chk($sformatf("%s/err/L%0d", nm, i+1), err_a[i], er);
        end
    endtask

    initial begin
        logic [31:0] ld_addr [5];
        logic [2:0]  ld_f3   [5];
        logic [31:0] ld_exp  [5];
        logic        e_we    [7];
        logic [2:0]  e_f3    [7];
        logic [31:0] e_addr  [7];
        logic [31:0] snap_resp [3];
        logic [31:0] snap_we   [3];
        logic [31:0] snap_acc  [3];
        logic [31:0] exp_acc   [3];

        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready/L%0d", i+1), ready_a[i], 32'd1);
            chk($sformatf("rst_rv/L%0d", i+1), rv_a[i], 32'd0);
            chk($sformatf("rst_err/L%0d", i+1), rerr_a[i], 32'd0);
            chk($sformatf("rst_rdata/L%0d", i+1), rdat_a[i], 32'd0);
            chk($sformatf("rst_en/L%0d", i+1), en_a[i], 32'd0);
            chk($sformatf("rst_we/L%0d", i+1), we_a[i], 32'd0);
            chk($sformatf("rst_addr/L%0d", i+1), addr_a[i], 32'd0);
            chk($sformatf("rst_din/L%0d", i+1), din_a[i], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
        chk_txn("sw_dead", 2, 1'b0, 1, 1, 32'h0, 32'h0);
        do_req(1'b0, F3_W, 32'h10, 32'h0);
        chk_txn("lw_dead", 2, 1'b1, 1, 0, 32'hDEAD_BEEF, 32'h0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("lw_dead/addr/L%0d", i+1), en_addr_a[i], 32'd4);

        do_req(1'b1, F3_W, 32'h10, 32'h80FF_7F01);
        ld_addr = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11};
        ld_f3   = '{F3_B, F3_BU, F3_H, F3_HU, F3_B};
        ld_exp  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_007F};
        for (int k = 0; k < 5; k++) begin
            do_req(1'b0, ld_f3[k], ld_addr[k], 32'h0);
            chk_txn($sformatf("ld%0d", k), 2, 1'b1, 1, 0, ld_exp[k], 32'h0);
        end

        do_req(1'b1, F3_W, 32'h10, 32'h1122_3344);
        do_req(1'b1, F3_B, 32'h11, 32'h1234_56AA);
        chk_txn("sb", 3, 1'b1, 2, 1, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb/wcyc/L%0d", i+1), we_cyc_a[i], 32'(2 + i + 1));
            chk($sformatf("sb/din/L%0d", i+1), we_din_a[i], 32'h1122_AA44);
        end
        do_req(1'b1, F3_H, 32'h12, 32'hFFFF_BEEF);
        chk_txn("sh", 3, 1'b1, 2, 1, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("sh/din/L%0d", i+1), we_din_a[i], 32'hBEEF_AA44);
        do_req(1'b0, F3_W, 32'h10, 32'h0);
        chk_txn("lw_merged", 2, 1'b1, 1, 0, 32'hBEEF_AA44, 32'h0);

        e_we   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        e_f3   = '{F3_H, F3_W, 3'b011, F3_BU, F3_W, 3'b110, F3_B};
        e_addr = '{32'h07, 32'h02, 32'h00, 32'h00, 32'h1000, 32'h00, 32'hFFFF_FFFF};
        for (int k = 0; k < 7; k++) begin
            do_req(e_we[k], e_f3[k], e_addr[k], 32'hFFFF_FFFF);
            chk_txn($sformatf("err%0d", k), 1, 1'b0, 0, 0, 32'h0, 32'h1);
        end

        do_req(1'b1, F3_W, 32'hFFC, 32'h1234_5678);
        chk_txn("sw_last", 2, 1'b0, 1, 1, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("sw_last/addr/L%0d", i+1), en_addr_a[i], 32'h3FF);
        do_req(1'b0, F3_W, 32'hFFC, 32'h0);
        chk_txn("lw_last", 2, 1'b1, 1, 0, 32'h1234_5678, 32'h0);
        do_req(1'b0, F3_BU, 32'hFFF, 32'h0);
        chk_txn("lbu_last", 2, 1'b1, 1, 0, 32'h0000_0012, 32'h0);

        // reset during the read-latency wait of a half store
        do_req(1'b1, F3_W, 32'h20, 32'h5566_7788);
        snap_resp = resp_tot_a;
        snap_we   = we_tot_a;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h22; req_wdata = 32'h0000_1234;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstmid_en/L%0d", i+1), en_a[i], 32'd0);
            chk($sformatf("rstmid_we/L%0d", i+1), we_a[i], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstmid_ready/L%0d", i+1), ready_a[i], 32'd1);
            chk($sformatf("rstmid_resp/L%0d", i+1), resp_tot_a[i] - snap_resp[i], 32'd0);
            chk($sformatf("rstmid_write/L%0d", i+1), we_tot_a[i] - snap_we[i], 32'd0);
        end
        do_req(1'b0, F3_W, 32'h20, 32'h0);
        chk_txn("lw_after_rst", 2, 1'b1, 1, 0, 32'h5566_7788, 32'h0);

        // req_valid held for 12 edges: back-to-back accepts every 3+RD_LAT edges
        snap_acc = acc_tot_a;
        exp_acc  = '{32'd3, 32'd3, 32'd2};
        @(negedge clk);
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h0;
        req_valid = 1'b1;
        repeat (12) @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("held_acc/L%0d", i+1), acc_tot_a[i] - snap_acc[i], exp_acc[i]);
            chk($sformatf("held_gap/L%0d", i+1), gap_a[i], 32'd1);
            chk($sformatf("held_rdata/L%0d", i+1), rdata_a[i], 32'h5566_7788);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

endmodule
